// File: rtl/io_uart.sv
// io_uart: memory-mapped UART with a TX byte FIFO feeding a serial transmitter.
// Define IO_UART_RX_EN to build the receiver; otherwise RX status and data read as zero.
module io_uart #(
   parameter int unsigned CLK_DIV    = 434,
   parameter int unsigned FIFO_DEPTH = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        ce,
   input  logic        we,
   input  logic [31:0] addr,
   input  logic [31:0] wtData,
   output logic [31:0] rdData,
   output logic        txd,
   input  logic        rxd
);
   localparam int unsigned AW = $clog2(FIFO_DEPTH);
   localparam int unsigned CW = AW + 1;
   localparam int unsigned DW = 16;

   typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} txState_t;

   logic wrTx, wrStat, wrDiv, rdRx;
   assign wrTx   = ce & we  & (addr[3:2] == 2'd0);
   assign wrStat = ce & we  & (addr[3:2] == 2'd1);
   assign wrDiv  = ce & we  & (addr[3:2] == 2'd3);
   assign rdRx   = ce & ~we & (addr[3:2] == 2'd2);

   logic [DW-1:0] divisor;
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)       divisor <= DW'(CLK_DIV);
      else if (wrDiv) divisor <= (wtData[15:0] == 16'd0) ? DW'(1) : wtData[15:0];
   end

   // TX FIFO; a push into a full FIFO is accepted only when the head pops in the same cycle
   logic [7:0]    fifoMem [FIFO_DEPTH];
   logic [AW-1:0] wrPtr, rdPtr;
   logic [CW-1:0] count;
   logic          fifoFull, fifoEmpty, push, pop, txOvfSet, txOvf;

   assign fifoFull  = (count == CW'(FIFO_DEPTH));
   assign fifoEmpty = (count == '0);
   assign push      = wrTx & (~fifoFull | pop);
   assign txOvfSet  = wrTx & fifoFull & ~pop;

   always_ff @(posedge clk) begin
      if (push) fifoMem[wrPtr] <= wtData[7:0];
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wrPtr <= '0;
         rdPtr <= '0;
         count <= '0;
         txOvf <= 1'b0;
      end else begin
         if (push) wrPtr <= wrPtr + AW'(1);
         if (pop)  rdPtr <= rdPtr + AW'(1);
         if (push & ~pop)      count <= count + CW'(1);
         else if (pop & ~push) count <= count - CW'(1);
         if (txOvfSet)                 txOvf <= 1'b1;
         else if (wrStat & wtData[4])  txOvf <= 1'b0;
      end
   end

   txState_t      txState, txStateNext;
   logic [DW-1:0] txCnt, txCntNext;
   logic [2:0]    txBit, txBitNext;
   logic [7:0]    txShift, txShiftNext;
   logic          txdNext;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         txState <= TX_IDLE;
         txCnt   <= '0;
         txBit   <= '0;
         txShift <= '0;
         txd     <= 1'b1;
      end else begin
         txState <= txStateNext;
         txCnt   <= txCntNext;
         txBit   <= txBitNext;
         txShift <= txShiftNext;
         txd     <= txdNext;
      end
   end

   // Bit timer reloads from the live divisor, so divisor writes apply at the next bit boundary
   always_comb begin
      txStateNext = txState;
      txCntNext   = txCnt;
      txBitNext   = txBit;
      txShiftNext = txShift;
      txdNext     = txd;
      pop         = 1'b0;
      case (txState)
         TX_IDLE: begin
            if (!fifoEmpty) begin
               pop         = 1'b1;
               txStateNext = TX_START;
               txCntNext   = divisor - DW'(1);
               txShiftNext = fifoMem[rdPtr];
               txdNext     = 1'b0;
            end
         end
         TX_START: begin
            if (txCnt == '0) begin
               txStateNext = TX_DATA;
               txCntNext   = divisor - DW'(1);
               txBitNext   = '0;
               txdNext     = txShift[0];
            end else begin
               txCntNext = txCnt - DW'(1);
            end
         end
         TX_DATA: begin
            if (txCnt == '0) begin
               txCntNext = divisor - DW'(1);
               if (txBit == 3'd7) begin
                  txStateNext = TX_STOP;
                  txdNext     = 1'b1;
               end else begin
                  txBitNext   = txBit + 3'd1;
                  txShiftNext = txShift >> 1;
                  txdNext     = txShift[1];
               end
            end else begin
               txCntNext = txCnt - DW'(1);
            end
         end
         TX_STOP: begin
            if (txCnt == '0) begin
               if (!fifoEmpty) begin
                  pop         = 1'b1;
                  txStateNext = TX_START;
                  txCntNext   = divisor - DW'(1);
                  txShiftNext = fifoMem[rdPtr];
                  txdNext     = 1'b0;
               end else begin
                  txStateNext = TX_IDLE;
                  txdNext     = 1'b1;
               end
            end else begin
               txCntNext = txCnt - DW'(1);
            end
         end
         default: txStateNext = TX_IDLE;
      endcase
   end

   logic       rxValid, rxOvf, frameErr;
   logic [7:0] rxByte;

`ifdef IO_UART_RX_EN
   typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT} rxState_t;

   rxState_t      rxState, rxStateNext;
   logic [DW-1:0] rxCnt, rxCntNext;
   logic [2:0]    rxBit, rxBitNext;
   logic [7:0]    rxShift, rxShiftNext;
   logic          rxS1, rxS2, rxPrev, rxDone, rxBad;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rxS1     <= 1'b1;
         rxS2     <= 1'b1;
         rxPrev   <= 1'b1;
         rxState  <= RX_IDLE;
         rxCnt    <= '0;
         rxBit    <= '0;
         rxShift  <= '0;
         rxValid  <= 1'b0;
         rxByte   <= '0;
         rxOvf    <= 1'b0;
         frameErr <= 1'b0;
      end else begin
         rxS1    <= rxd;
         rxS2    <= rxS1;
         rxPrev  <= rxS2;
         rxState <= rxStateNext;
         rxCnt   <= rxCntNext;
         rxBit   <= rxBitNext;
         rxShift <= rxShiftNext;
         // A load coinciding with a CPU read replaces the byte without flagging overflow
         if (rxDone & (~rxValid | rdRx)) begin
            rxValid <= 1'b1;
            rxByte  <= rxShift;
         end else if (rdRx) begin
            rxValid <= 1'b0;
         end
         if (rxDone & rxValid & ~rdRx)    rxOvf <= 1'b1;
         else if (wrStat & wtData[5])     rxOvf <= 1'b0;
         if (rxBad)                       frameErr <= 1'b1;
         else if (wrStat & wtData[6])     frameErr <= 1'b0;
      end
   end

   always_comb begin
      rxStateNext = rxState;
      rxCntNext   = rxCnt;
      rxBitNext   = rxBit;
      rxShiftNext = rxShift;
      rxDone      = 1'b0;
      rxBad       = 1'b0;
      case (rxState)
         RX_IDLE: begin
            if (rxPrev & ~rxS2) begin
               rxStateNext = RX_START;
               rxCntNext   = divisor >> 1;
            end
         end
         RX_START: begin
            if (rxCnt == '0) begin
               if (!rxS2) begin
                  rxStateNext = RX_DATA;
                  rxCntNext   = divisor - DW'(1);
                  rxBitNext   = '0;
               end else begin
                  rxStateNext = RX_IDLE;
               end
            end else begin
               rxCntNext = rxCnt - DW'(1);
            end
         end
         RX_DATA: begin
            if (rxCnt == '0) begin
               rxShiftNext = {rxS2, rxShift[7:1]};
               rxCntNext   = divisor - DW'(1);
               if (rxBit == 3'd7) rxStateNext = RX_STOP;
               else               rxBitNext   = rxBit + 3'd1;
            end else begin
               rxCntNext = rxCnt - DW'(1);
            end
         end
         RX_STOP: begin
            if (rxCnt == '0) begin
               if (rxS2) begin
                  rxDone      = 1'b1;
                  rxStateNext = RX_IDLE;
               end else begin
                  rxBad       = 1'b1;
                  rxStateNext = RX_WAIT;
               end
            end else begin
               rxCntNext = rxCnt - DW'(1);
            end
         end
         RX_WAIT: begin
            if (rxS2) rxStateNext = RX_IDLE;
         end
         default: rxStateNext = RX_IDLE;
      endcase
   end

   logic unusedBits;
   assign unusedBits = ^{addr[31:4], addr[1:0], wtData[31:16]};
`else
   assign rxValid  = 1'b0;
   assign rxOvf    = 1'b0;
   assign frameErr = 1'b0;
   assign rxByte   = 8'd0;

   logic unusedBits;
   assign unusedBits = ^{addr[31:4], addr[1:0], wtData[31:16], rxd, rdRx};
`endif

   // Zero-latency read mux
   always_comb begin
      rdData = 32'd0;
      if (ce && !we) begin
         case (addr[3:2])
            2'd1: rdData = {25'd0, frameErr, rxOvf, txOvf, rxValid,
                            (txState != TX_IDLE), fifoEmpty, fifoFull};
            2'd2: rdData = {24'd0, rxByte};
            2'd3: rdData = {16'd0, divisor};
            default: rdData = 32'd0;
         endcase
      end
   end

endmodule

// File: tb/tb_io_uart.sv
// tb_io_uart: directed self-checking bench for io_uart (RX scenarios when IO_UART_RX_EN is defined).
module tb_io_uart;
   logic        clk = 1'b0;
   logic        rst, ce, we, txd, rxd;
   logic [31:0] addr, wtData, rdData;
   int          checks = 0;
   int          failures = 0;

   localparam logic [31:0] A_TX = 32'd0, A_ST = 32'd4, A_RX = 32'd8, A_DIV = 32'd12;

   io_uart #(.CLK_DIV(434), .FIFO_DEPTH(8)) dut (
      .clk(clk), .rst(rst), .ce(ce), .we(we), .addr(addr),
      .wtData(wtData), .rdData(rdData), .txd(txd), .rxd(rxd)
   );

   always #5 clk = ~clk;

   task automatic wr(input logic [31:0] a, input logic [31:0] d);
      @(negedge clk); ce = 1'b1; we = 1'b1; addr = a; wtData = d;
      @(negedge clk); ce = 1'b0; we = 1'b0;
   endtask

   task automatic rd(input logic [31:0] a, output logic [31:0] d);
      @(negedge clk); ce = 1'b1; we = 1'b0; addr = a;
      #1 d = rdData;
      @(negedge clk); ce = 1'b0;
   endtask

   task automatic send_rx(input logic [7:0] b, input logic stopBit, input int div);
      logic [9:0] f;
      f = {stopBit, b, 1'b0};
      for (int k = 0; k < 10; k++) begin
         @(negedge clk); rxd = f[k];
         repeat (div - 1) @(negedge clk);
      end
      @(negedge clk); rxd = 1'b1;
      repeat (10) @(negedge clk);
   endtask

   task automatic test_reset;
      logic [31:0] d;
      int bad;
      rst = 1'b1; ce = 1'b0; we = 1'b0; addr = '0; wtData = '0; rxd = 1'b1;
      #2 rst = 1'b0;
      #1;
      checks++;
      if (txd !== 1'b1) begin failures++; $display("FAIL reset_txd: txd=%b required 1", txd); end
      repeat (3) @(negedge clk);
      rst = 1'b1;
      rd(A_DIV, d);
      checks++;
      if (d !== 32'h1B2) begin failures++; $display("FAIL reset_divisor: read %h required 000001b2", d); end
      rd(A_ST, d);
      checks++;
      if (d !== 32'h2) begin failures++; $display("FAIL reset_status: read %h required 00000002", d); end
      bad = 0;
      repeat (20) begin @(negedge clk); if (txd !== 1'b1) bad++; end
      checks++;
      if (bad != 0) begin failures++; $display("FAIL reset_idle_txd: txd low for %0d cycles required 0", bad); end
   endtask

   task automatic test_divisor;
      logic [31:0] d;
      @(negedge clk); ce = 1'b1; we = 1'b1; addr = A_DIV; wtData = 32'h0;
      #1;
      checks++;
      if (rdData !== 32'h0) begin failures++; $display("FAIL write_cycle_rddata: read %h required 00000000", rdData); end
      @(negedge clk); ce = 1'b0; we = 1'b0;
      rd(A_DIV, d);
      checks++;
      if (d !== 32'h1) begin failures++; $display("FAIL divisor_zero: read %h required 00000001", d); end
      wr(A_DIV, 32'hABCD_0123);
      rd(A_DIV, d);
      checks++;
      if (d !== 32'h0123) begin failures++; $display("FAIL divisor_rw: read %h required 00000123", d); end
      rd(A_TX, d);
      checks++;
      if (d !== 32'h0) begin failures++; $display("FAIL txdata_read: read %h required 00000000", d); end
   endtask

   task automatic test_tx_frame;
      logic [9:0]  bits;
      logic [31:0] d;
      logic        busyAll;
      int          bad;
      bits = {1'b1, 8'hA5, 1'b0};
      busyAll = 1'b1;
      wr(A_DIV, 32'd4);
      wr(A_TX, 32'hA5);
      ce = 1'b1; we = 1'b0; addr = A_ST;
      for (int k = 0; k < 10; k++) begin
         bad = 0;
         for (int s = 0; s < 4; s++) begin
            @(negedge clk);
            if (txd !== bits[k]) bad++;
            if (rdData[2] !== 1'b1) busyAll = 1'b0;
         end
         checks++;
         if (bad != 0) begin
            failures++;
            $display("FAIL tx_frame_bit%0d: txd wrong for %0d of 4 cycles, required %b", k, bad, bits[k]);
         end
      end
      ce = 1'b0;
      checks++;
      if (busyAll !== 1'b1) begin failures++; $display("FAIL tx_busy: busy=%b during frame required 1", busyAll); end
      rd(A_ST, d);
      checks++;
      if (d !== 32'h2) begin failures++; $display("FAIL tx_done_status: read %h required 00000002", d); end
   endtask

   task automatic test_back_to_back;
      logic        samples[$];
      logic [31:0] d;
      logic [19:0] exp;
      logic [7:0]  b;
      int          bad;
      wr(A_DIV, 32'd2);
      fork
         begin
            for (int i = 0; i < 9; i++) begin
               @(negedge clk); ce = 1'b1; we = 1'b1; addr = A_TX; wtData = 32'(i);
            end
            @(negedge clk); we = 1'b0; addr = A_ST;
            #1;
            checks++;
            if (rdData !== 32'h05) begin failures++; $display("FAIL fifo_full_status: read %h required 00000005", rdData); end
            @(negedge clk); we = 1'b1; addr = A_TX; wtData = 32'hFF;
            @(negedge clk); we = 1'b0; addr = A_ST;
            #1;
            checks++;
            if (rdData !== 32'h15) begin failures++; $display("FAIL tx_ovf_set: read %h required 00000015", rdData); end
            @(negedge clk); we = 1'b1; addr = A_ST; wtData = 32'h10;
            @(negedge clk); we = 1'b0; addr = A_ST;
            #1;
            checks++;
            if (rdData !== 32'h05) begin failures++; $display("FAIL tx_ovf_clear: read %h required 00000005", rdData); end
            @(negedge clk); ce = 1'b0;
         end
         begin
            repeat (2) @(negedge clk);
            for (int n = 0; n < 180; n++) begin @(negedge clk); samples.push_back(txd); end
         end
      join
      for (int f = 0; f < 9; f++) begin
         b = 8'(f);
         for (int k = 0; k < 10; k++) begin
            exp[2*k]   = (k == 0) ? 1'b0 : (k == 9) ? 1'b1 : b[k-1];
            exp[2*k+1] = exp[2*k];
         end
         bad = 0;
         for (int s = 0; s < 20; s++) if (samples[f*20+s] !== exp[s]) bad++;
         checks++;
         if (bad != 0) begin
            failures++;
            $display("FAIL b2b_frame%0d: %0d of 20 samples wrong, required byte %h", f, bad, b);
         end
      end
      rd(A_ST, d);
      checks++;
      if (d !== 32'h2) begin failures++; $display("FAIL b2b_idle_status: read %h required 00000002", d); end
   endtask

`ifdef IO_UART_RX_EN
   task automatic test_rx;
      logic [31:0] d;
      wr(A_DIV, 32'd8);
      send_rx(8'h3C, 1'b1, 8);
      rd(A_ST, d);
      checks++;
      if (d !== 32'h0A) begin failures++; $display("FAIL rx_valid: status %h required 0000000a", d); end
      rd(A_RX, d);
      checks++;
      if (d !== 32'h3C) begin failures++; $display("FAIL rx_data: read %h required 0000003c", d); end
      rd(A_ST, d);
      checks++;
      if (d !== 32'h02) begin failures++; $display("FAIL rx_valid_clear: status %h required 00000002", d); end
      send_rx(8'h3C, 1'b1, 8);
      send_rx(8'h77, 1'b1, 8);
      rd(A_ST, d);
      checks++;
      if (d !== 32'h2A) begin failures++; $display("FAIL rx_ovf: status %h required 0000002a", d); end
      rd(A_RX, d);
      checks++;
      if (d !== 32'h3C) begin failures++; $display("FAIL rx_ovf_keep: read %h required 0000003c", d); end
      wr(A_ST, 32'h20);
      rd(A_ST, d);
      checks++;
      if (d !== 32'h02) begin failures++; $display("FAIL rx_ovf_clear: status %h required 00000002", d); end
   endtask

   task automatic test_rx_errors;
      logic [31:0] d;
      send_rx(8'h55, 1'b0, 8);
      rd(A_ST, d);
      checks++;
      if (d !== 32'h42) begin failures++; $display("FAIL frame_err: status %h required 00000042", d); end
      wr(A_ST, 32'h40);
      @(negedge clk); rxd = 1'b0;
      repeat (2) @(negedge clk);
      rxd = 1'b1;
      repeat (100) @(negedge clk);
      rd(A_ST, d);
      checks++;
      if (d !== 32'h02) begin failures++; $display("FAIL glitch_reject: status %h required 00000002", d); end
      send_rx(8'hC3, 1'b1, 8);
      rd(A_RX, d);
      checks++;
      if (d !== 32'hC3) begin failures++; $display("FAIL rx_after_glitch: read %h required 000000c3", d); end
   endtask
`else
   task automatic test_rx_disabled;
      logic [31:0] d;
      wr(A_DIV, 32'd8);
      send_rx(8'h3C, 1'b1, 8);
      rd(A_ST, d);
      checks++;
      if (d !== 32'h02) begin failures++; $display("FAIL rx_off_status: status %h required 00000002", d); end
      rd(A_RX, d);
      checks++;
      if (d !== 32'h0) begin failures++; $display("FAIL rx_off_data: read %h required 00000000", d); end
   endtask
`endif

   task automatic test_reset_midframe;
      logic [31:0] d;
      int bad;
      wr(A_DIV, 32'd4);
      wr(A_TX, 32'hA5);
      wr(A_TX, 32'h33);
      repeat (16) @(negedge clk);
      checks++;
      if (txd !== 1'b0) begin failures++; $display("FAIL midframe_bit3: txd=%b required 0", txd); end
      rst = 1'b0;
      #1;
      checks++;
      if (txd !== 1'b1) begin failures++; $display("FAIL midframe_reset_txd: txd=%b required 1", txd); end
      rd(A_ST, d);
      checks++;
      if (d !== 32'h2) begin failures++; $display("FAIL midframe_reset_status: read %h required 00000002", d); end
      rd(A_DIV, d);
      checks++;
      if (d !== 32'h1B2) begin failures++; $display("FAIL midframe_reset_divisor: read %h required 000001b2", d); end
      @(negedge clk); rst = 1'b1;
      bad = 0;
      repeat (30) begin @(negedge clk); if (txd !== 1'b1) bad++; end
      checks++;
      if (bad != 0) begin failures++; $display("FAIL post_reset_idle: txd low for %0d cycles required 0", bad); end
      rd(A_ST, d);
      checks++;
      if (d !== 32'h2) begin failures++; $display("FAIL post_reset_status: read %h required 00000002", d); end
   endtask

   initial begin
      test_reset();
      test_divisor();
      test_tx_frame();
      test_back_to_back();
`ifdef IO_UART_RX_EN
      test_rx();
      test_rx_errors();
`else
      test_rx_disabled();
`endif
      test_reset_midframe();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
